bht_resolve_queue: RTL and testbench

Tracks every prediction issued by the fetch stage until the matching instruction resolves in execute. It then produces the branch-history-table update (write enable, taken flag, branch PC, taken target) and, on mismatch, a one-cycle redirect with queue flush. It sits between fetch (which pushes PC, PC+4 and the BHT `guess_addr`) and the BHT write port.

---
 rtl/bht_resolve_queue.sv | 138 +++++++++++++
 tb/tb_bht_resolve_queue.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bht_resolve_queue.sv
// rtl/bht_resolve_queue.sv - in-flight branch prediction queue producing BHT updates and mispredict redirects
module bht_resolve_queue #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [ADDR_W-1:0] push_pc4,
  input  logic [ADDR_W-1:0] push_guess,
  input  logic              res_valid,
  input  logic              res_is_branch,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              w_en,
  output logic              succeed,
  output logic [ADDR_W-1:0] pc_before_g,
  output logic [ADDR_W-1:0] g_addr,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [ADDR_W-1:0] pc4_mem   [DEPTH];
  logic [ADDR_W-1:0] guess_mem [DEPTH];

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              w_en_q, succeed_q, mispredict_q, ovf_err_q, unf_err_q;
  logic [ADDR_W-1:0] pc_before_g_q, g_addr_q, redirect_pc_q;

  logic              full_c, empty_c;
  logic              pop_v, push_ok, miss;
  logic              bht_wr;
  logic              ovf_set, unf_set;
  logic [ADDR_W-1:0] head_pc, head_pc4, head_guess, actual;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);

  assign head_pc    = pc_mem[head_q];
  assign head_pc4   = pc4_mem[head_q];
  assign head_guess = guess_mem[head_q];

  assign pop_v   = en && res_valid && !empty_c;
  assign actual  = res_taken ? res_target : head_pc4;
  assign miss    = pop_v && (actual != head_guess);
  assign bht_wr  = pop_v && res_is_branch;
  // A mispredict flushes wrong-path work, so a same-cycle push is discarded too.
  assign push_ok = en && push && (!full_c || pop_v) && !miss;
  assign ovf_set = en && push && full_c && !pop_v;
  assign unf_set = en && res_valid && empty_c;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (miss) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + PW'(1);
      if (pop_v)   head_d = head_q + PW'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_v);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[tail_q]    <= push_pc;
      pc4_mem[tail_q]   <= push_pc4;
      guess_mem[tail_q] <= push_guess;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Pulses are recomputed every cycle; data outputs only move when a new event loads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_en_q        <= 1'b0;
      succeed_q     <= 1'b0;
      pc_before_g_q <= '0;
      g_addr_q      <= '0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      ovf_err_q     <= 1'b0;
      unf_err_q     <= 1'b0;
    end else begin
      w_en_q       <= bht_wr;
      mispredict_q <= miss;
      if (bht_wr) begin
        succeed_q     <= res_taken;
        pc_before_g_q <= head_pc;
        g_addr_q      <= res_target;
      end
      if (miss) redirect_pc_q <= actual;
      if (ovf_set) ovf_err_q <= 1'b1;
      if (unf_set) unf_err_q <= 1'b1;
    end
  end

  assign full        = full_c;
  assign empty       = empty_c;
  assign count       = count_q;
  assign w_en        = w_en_q;
  assign succeed     = succeed_q;
  assign pc_before_g = pc_before_g_q;
  assign g_addr      = g_addr_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign ovf_err     = ovf_err_q;
  assign unf_err     = unf_err_q;

endmodule

// File: tb/tb_bht_resolve_queue.sv
// tb/tb_bht_resolve_queue.sv - table-driven checks for bht_resolve_queue
module tb_bht_resolve_queue;

  logic       clk = 1'b0;
  logic       rst, en, push, res_valid, res_is_branch, res_taken;
  logic [9:0] push_pc, push_pc4, push_guess, res_target;
  logic       full, empty, w_en, succeed, mispredict, ovf_err, unf_err;
  logic [2:0] count;
  logic [9:0] pc_before_g, g_addr, redirect_pc;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bht_resolve_queue #(.ADDR_W(10), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .push(push),
    .push_pc(push_pc), .push_pc4(push_pc4), .push_guess(push_guess),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
    .res_target(res_target), .full(full), .empty(empty), .count(count),
    .w_en(w_en), .succeed(succeed), .pc_before_g(pc_before_g), .g_addr(g_addr),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  typedef struct {
    logic       rst, en, push;
    logic [9:0] pc, pc4, guess;
    logic       rv, br, tk;
    logic [9:0] tgt;
    logic       full, empty;
    logic [2:0] cnt;
    logic       w_en, succ;
    logic [9:0] pcb, ga;
    logic       misp;
    logic [9:0] redir;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic r, e, p, input logic [9:0] pc, pc4, g,
    input logic rv, br, tk, input logic [9:0] tgt,
    input logic [2:0] cnt, input logic we, sc, input logic [9:0] pcb, ga,
    input logic mp, input logic [9:0] rd, input logic ov, un);
    vec_t v;
    v.rst = r; v.en = e; v.push = p; v.pc = pc; v.pc4 = pc4; v.guess = g;
    v.rv = rv; v.br = br; v.tk = tk; v.tgt = tgt;
    v.cnt = cnt; v.full = (cnt == 3'd4); v.empty = (cnt == 3'd0);
    v.w_en = we; v.succ = sc; v.pcb = pcb; v.ga = ga;
    v.misp = mp; v.redir = rd; v.ovf = ov; v.unf = un;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, e, p, input logic [9:0] pc, pc4, g,
                       input logic rv, br, tk, input logic [9:0] tgt);
    rst = r; en = e; push = p; push_pc = pc; push_pc4 = pc4; push_guess = g;
    res_valid = rv; res_is_branch = br; res_taken = tk; res_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {full,empty,cnt,w_en,succ,pcb,ga,misp,redir,ovf,unf}=%h required %h",
                  name, act, exp);
  endtask

  function automatic logic [39:0] pack_dut();
    return {full, empty, count, w_en, succeed, pc_before_g, g_addr,
            mispredict, redirect_pc, ovf_err, unf_err};
  endfunction

  function automatic logic [39:0] pack_exp(input vec_t v);
    return {v.full, v.empty, v.cnt, v.w_en, v.succ, v.pcb, v.ga,
            v.misp, v.redir, v.ovf, v.unf};
  endfunction

  initial begin
    //   rst en push pc     pc4    guess  rv br tk tgt      cnt we sc pcb     ga      mp redir   ov un
    add(1, 0, 0, 10'h0,  10'h0,  10'h0,  0, 0, 0, 10'h0,   0, 0, 0, 10'h0,  10'h0,  0, 10'h0,  0, 0);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  0, 0, 0, 10'h0,   0, 0, 0, 10'h0,  10'h0,  0, 10'h0,  0, 0);
    add(0, 1, 1, 10'h10, 10'h11, 10'h20, 0, 0, 0, 10'h0,   1, 0, 0, 10'h0,  10'h0,  0, 10'h0,  0, 0);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  1, 1, 1, 10'h20,  0, 1, 1, 10'h10, 10'h20, 0, 10'h0,  0, 0);
    add(0, 1, 1, 10'h30, 10'h31, 10'h31, 0, 0, 0, 10'h0,   1, 0, 1, 10'h10, 10'h20, 0, 10'h0,  0, 0);
    add(0, 1, 1, 10'h34, 10'h35, 10'h35, 0, 0, 0, 10'h0,   2, 0, 1, 10'h10, 10'h20, 0, 10'h0,  0, 0);
    add(0, 1, 1, 10'h38, 10'h39, 10'h39, 0, 0, 0, 10'h0,   3, 0, 1, 10'h10, 10'h20, 0, 10'h0,  0, 0);
    add(0, 1, 1, 10'h3c, 10'h3d, 10'h3d, 1, 1, 1, 10'h40,  0, 1, 1, 10'h30, 10'h40, 1, 10'h40, 0, 0);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  0, 0, 0, 10'h0,   0, 0, 1, 10'h30, 10'h40, 0, 10'h40, 0, 0);
    add(0, 1, 1, 10'h50, 10'h51, 10'h55, 0, 0, 0, 10'h0,   1, 0, 1, 10'h30, 10'h40, 0, 10'h40, 0, 0);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  1, 0, 0, 10'h0,   0, 0, 1, 10'h30, 10'h40, 1, 10'h51, 0, 0);
    add(0, 1, 1, 10'h60, 10'h61, 10'h61, 0, 0, 0, 10'h0,   1, 0, 1, 10'h30, 10'h40, 0, 10'h51, 0, 0);
    add(0, 1, 1, 10'h64, 10'h65, 10'h65, 0, 0, 0, 10'h0,   2, 0, 1, 10'h30, 10'h40, 0, 10'h51, 0, 0);
    add(0, 1, 1, 10'h68, 10'h69, 10'h69, 0, 0, 0, 10'h0,   3, 0, 1, 10'h30, 10'h40, 0, 10'h51, 0, 0);
    add(0, 1, 1, 10'h6c, 10'h6d, 10'h6d, 0, 0, 0, 10'h0,   4, 0, 1, 10'h30, 10'h40, 0, 10'h51, 0, 0);
    add(0, 1, 1, 10'h70, 10'h71, 10'h71, 1, 1, 0, 10'h100, 4, 1, 0, 10'h60, 10'h100,0, 10'h51, 0, 0);
    add(0, 1, 1, 10'h74, 10'h75, 10'h75, 1, 1, 0, 10'h104, 4, 1, 0, 10'h64, 10'h104,0, 10'h51, 0, 0);
    add(0, 1, 1, 10'h78, 10'h79, 10'h79, 0, 0, 0, 10'h0,   4, 0, 0, 10'h64, 10'h104,0, 10'h51, 1, 0);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  1, 1, 0, 10'h0,   3, 1, 0, 10'h68, 10'h0,  0, 10'h51, 1, 0);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  1, 1, 0, 10'h0,   2, 1, 0, 10'h6c, 10'h0,  0, 10'h51, 1, 0);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  1, 1, 0, 10'h0,   1, 1, 0, 10'h70, 10'h0,  0, 10'h51, 1, 0);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  1, 1, 0, 10'h0,   0, 1, 0, 10'h74, 10'h0,  0, 10'h51, 1, 0);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  1, 1, 1, 10'h3ff, 0, 0, 0, 10'h74, 10'h0,  0, 10'h51, 1, 1);
    add(0, 0, 1, 10'h80, 10'h81, 10'h81, 1, 1, 1, 10'h0,   0, 0, 0, 10'h74, 10'h0,  0, 10'h51, 1, 1);
    add(0, 1, 1, 10'h90, 10'h91, 10'h91, 0, 0, 0, 10'h0,   1, 0, 0, 10'h74, 10'h0,  0, 10'h51, 1, 1);
    add(0, 0, 0, 10'h0,  10'h0,  10'h0,  1, 1, 1, 10'h200, 1, 0, 0, 10'h74, 10'h0,  0, 10'h51, 1, 1);
    add(0, 1, 0, 10'h0,  10'h0,  10'h0,  1, 1, 1, 10'h200, 0, 1, 1, 10'h90, 10'h200,1, 10'h200,1, 1);
    add(0, 0, 0, 10'h0,  10'h0,  10'h0,  0, 0, 0, 10'h0,   0, 0, 1, 10'h90, 10'h200,0, 10'h200,1, 1);
    add(0, 1, 1, 10'ha0, 10'ha1, 10'ha1, 0, 0, 0, 10'h0,   1, 0, 1, 10'h90, 10'h200,0, 10'h200,1, 1);
    add(1, 1, 1, 10'hb0, 10'hb1, 10'hb1, 1, 1, 1, 10'h2,   0, 0, 0, 10'h0,  10'h0,  0, 10'h0,  0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].push, vecs[i].pc, vecs[i].pc4, vecs[i].guess,
            vecs[i].rv, vecs[i].br, vecs[i].tk, vecs[i].tgt);
      check($sformatf("vec%0d", i), pack_dut(), pack_exp(vecs[i]));
    end

    // Sustained push+pop at full depth: order must survive several pointer wraps.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      drive(0, 1, 1, 10'(k * 8), 10'(k * 8 + 1), 10'(k * 8 + 1), 0, 0, 0, 0);
    for (int k = 4; k < 11; k++) begin
      drive(0, 1, 1, 10'(k * 8), 10'(k * 8 + 1), 10'(k * 8 + 1), 1, 1, 0, 10'(k));
      check($sformatf("wrap%0d", k), pack_dut(),
            {1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 10'((k - 4) * 8), 10'(k), 1'b0, 10'h0, 1'b0, 1'b0});
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0, 0, 0, 1, 1, 1, 10'((k + 7) * 8 + 1));
      check($sformatf("drain%0d", k), pack_dut(),
            {1'b0, (k == 3), 3'(3 - k), 1'b1, 1'b1, 10'((k + 7) * 8), 10'((k + 7) * 8 + 1),
             1'b0, 10'h0, 1'b0, 1'b0});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
